// File: rtl/seq_pkg.sv
// seq_pkg
//   Definitions shared by the sequencer pattern-memory blocks (writer,
//   pattern RAM and readback engine).
//   - SEQ_WORDS / SEQ_ADDR_W : pattern memory depth and address width.
//   - seq_state_e            : readback engine state encoding.
package seq_pkg;

    localparam int SEQ_WORDS  = 64;
    localparam int SEQ_ADDR_W = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        HI    = 3'd3,
        LO    = 3'd4,
        DONE  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/sync_edge.sv
// sync_edge
//   Synchroniser chain for an asynchronous input, with a one-cycle pulse
//   on each rising edge of the synchronised level.
//   Ports:
//     clk    - system clock
//     rst    - asynchronous active-high reset
//     d_i    - asynchronous input
//     lvl_o  - synchronised level (STAGES flops after d_i)
//     rise_o - one-cycle pulse when lvl_o goes 0 -> 1
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign lvl_o  = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/seq_rdback.sv
// seq_rdback
//   Host readback engine for the sequencer pattern memory. Fetches 16-bit
//   words from the pattern RAM in ascending address order and presents them
//   to the host high byte first, one byte per host strobe.
//   Ports:
//     clk      - system clock (single domain)
//     rst      - asynchronous active-high reset
//     rd       - host session enable, asynchronous level
//     Stb      - host byte strobe, asynchronous; rising edge consumes a byte
//     mem_rd   - pattern RAM read enable, one-cycle pulse
//     mem_addr - pattern RAM read address
//     mem_data - RAM read data, valid one clk after the mem_rd cycle
//     dato_out - byte presented to the host
//     dato_oe  - dato_out valid / host bus driver enable
//     done     - all 2*WORDS bytes consumed
//     ovr      - sticky: strobe arrived while no byte was ready
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no session; outputs quiet, index at 0
//   FETCH | mem_rd pulse issued for the current word index
//   LOAD  | RAM data valid; captured into the word register
//   HI    | high byte presented, waiting for strobe
//   LO    | low byte presented, waiting for strobe
//   DONE  | every byte consumed; strobes ignored
module seq_rdback
    import seq_pkg::*;
#(
    parameter int WORDS       = SEQ_WORDS,
    parameter int ADDR_W      = SEQ_ADDR_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              Stb,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    output logic [7:0]        dato_out,
    output logic              dato_oe,
    output logic              done,
    output logic              ovr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

    logic rd_s;
    logic stb_p;
    logic rd_rise_unused;
    logic stb_lvl_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rd (
        .clk    (clk),
        .rst    (rst),
        .d_i    (rd),
        .lvl_o  (rd_s),
        .rise_o (rd_rise_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stb (
        .clk    (clk),
        .rst    (rst),
        .d_i    (Stb),
        .lvl_o  (stb_lvl_unused),
        .rise_o (stb_p)
    );

    seq_state_e        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic [15:0]       word_q;
    logic              mem_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        dato_out_q;
    logic              dato_oe_q;
    logic              done_q;
    logic              ovr_q;

    // Never wraps: DONE is taken at LAST_IDX before the increment is used.
    assign idx_d = idx_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            dato_out_q <= 8'h00;
            dato_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else if (!rd_s) begin
            // Session closed from any state: back to a clean IDLE.
            state_q    <= IDLE;
            idx_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            dato_out_q <= 8'h00;
            dato_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    idx_q      <= '0;
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= '0;
                end
                FETCH: begin
                    state_q  <= LOAD;
                    mem_rd_q <= 1'b0;
                    if (stb_p) ovr_q <= 1'b1;
                end
                LOAD: begin
                    // RAM data is valid this cycle; present the high byte
                    // straight from it so HI shows it on entry.
                    state_q    <= HI;
                    word_q     <= mem_data;
                    dato_out_q <= mem_data[15:8];
                    dato_oe_q  <= 1'b1;
                    if (stb_p) ovr_q <= 1'b1;
                end
                HI: begin
                    if (stb_p) begin
                        state_q    <= LO;
                        dato_out_q <= word_q[7:0];
                    end
                end
                LO: begin
                    if (stb_p) begin
                        dato_oe_q  <= 1'b0;
                        dato_out_q <= 8'h00;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= FETCH;
                            idx_q      <= idx_d;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= idx_d;
                        end
                    end
                end
                DONE: begin
                    dato_oe_q  <= 1'b0;
                    dato_out_q <= 8'h00;
                    done_q     <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign dato_out = dato_out_q;
    assign dato_oe  = dato_oe_q;
    assign done     = done_q;
    assign ovr      = ovr_q;

endmodule

// File: tb/tb_seq_rdback.sv
module tb_seq_rdback;

    logic        clk;
    logic        rst;
    logic        rd;
    logic        Stb;
    logic        mem_rd;
    logic [5:0]  mem_addr;
    logic [15:0] mem_data;
    logic [7:0]  dato_out;
    logic        dato_oe;
    logic        done;
    logic        ovr;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem [0:63];
    logic [5:0]  rd_addrs [0:511];
    int          n_rd = 0;

    seq_rdback #(.WORDS(64), .ADDR_W(6), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd       (rd),
        .Stb      (Stb),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .dato_out (dato_out),
        .dato_oe  (dato_oe),
        .done     (done),
        .ovr      (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern RAM model: data valid one clock after the read cycle.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data <= mem[mem_addr];
            if (n_rd < 512) rd_addrs[n_rd] = mem_addr;
            n_rd = n_rd + 1;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Clean strobe: high two cycles, low three; consumed before return.
    task automatic strobe();
        Stb = 1'b1;
        repeat (2) @(negedge clk);
        Stb = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_oe();
        int t;
        t = 0;
        while (!dato_oe && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk1("oe_wait", dato_oe, 1'b1);
    endtask

    task automatic get_byte(output logic [7:0] b);
        wait_oe();
        b = dato_out;
        strobe();
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] w;
        int          n0;

        for (int i = 0; i < 64; i++) mem[i] = 16'h1404 + 16'(i);
        mem_data = 16'h0000;
        rst = 1'b1;
        rd  = 1'b1;
        Stb = 1'b0;

        // Reset held with rd high and Stb toggling.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            Stb = ~Stb;
            chk1("rst_mem_rd", mem_rd, 1'b0);
            chk1("rst_oe", dato_oe, 1'b0);
        end
        chk8("rst_dato", dato_out, 8'h00);
        chk1("rst_done", done, 1'b0);
        chk1("rst_ovr", ovr, 1'b0);
        chkn("rst_no_reads", n_rd, 0);
        Stb = 1'b0;
        rd  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Full readback with first-byte latency check.
        rd = 1'b1;
        repeat (3) @(negedge clk);
        chk1("lat_fetch_mem_rd", mem_rd, 1'b1);
        chk1("lat_fetch_oe", dato_oe, 1'b0);
        @(negedge clk);
        chk1("lat_load_oe", dato_oe, 1'b0);
        @(negedge clk);
        chk1("lat_hi_oe", dato_oe, 1'b1);
        chk8("lat_hi_byte", dato_out, 8'h14);
        for (int i = 0; i < 64; i++) begin
            w = 16'h1404 + 16'(i);
            get_byte(b);
            chk8("full_hi", b, w[15:8]);
            get_byte(b);
            chk8("full_lo", b, w[7:0]);
        end
        chk1("full_done", done, 1'b1);
        chk1("full_oe_low", dato_oe, 1'b0);
        chk8("full_dato_zero", dato_out, 8'h00);
        chk1("full_ovr", ovr, 1'b0);
        chkn("full_rd_count", n_rd, 64);
        for (int i = 0; i < 64; i++) chk8("full_addr", {2'b00, rd_addrs[i]}, 8'(i));

        // Post-done strobes are ignored.
        for (int i = 0; i < 10; i++) begin
            strobe();
            chk1("post_done", done, 1'b1);
            chk1("post_ovr", ovr, 1'b0);
            chk8("post_dato", dato_out, 8'h00);
        end
        chkn("post_no_reads", n_rd, 64);

        // Close session: done clears.
        rd = 1'b0;
        repeat (4) @(negedge clk);
        chk1("close_done", done, 1'b0);
        chk1("close_oe", dato_oe, 1'b0);

        // Overrun: second strobe lands in FETCH/LOAD.
        n0 = n_rd;
        rd = 1'b1;
        get_byte(b);
        chk8("ovr_hi0", b, 8'h14);
        wait_oe();
        chk8("ovr_lo0", dato_out, 8'h04);
        Stb = 1'b1; @(negedge clk);
        Stb = 1'b0; @(negedge clk);
        Stb = 1'b1; @(negedge clk);
        Stb = 1'b0;
        repeat (4) @(negedge clk);
        chk1("ovr_set", ovr, 1'b1);
        get_byte(b);
        chk8("ovr_next_hi1", b, 8'h14);
        get_byte(b);
        chk8("ovr_next_lo1", b, 8'h05);
        chk1("ovr_sticky", ovr, 1'b1);
        chk8("ovr_addr0", {2'b00, rd_addrs[n0]}, 8'd0);
        chk8("ovr_addr1", {2'b00, rd_addrs[n0+1]}, 8'd1);
        get_byte(b);
        chk8("ovr_hi2", b, 8'h14);

        // Abort after 5 bytes and restart at word 0.
        rd = 1'b0;
        repeat (4) @(negedge clk);
        chk1("abort_ovr_clr", ovr, 1'b0);
        chk1("abort_done_clr", done, 1'b0);
        chk1("abort_oe", dato_oe, 1'b0);
        n0 = n_rd;
        rd = 1'b1;
        get_byte(b);
        chk8("restart_hi0", b, 8'h14);
        get_byte(b);
        chk8("restart_lo0", b, 8'h04);
        chk8("restart_addr0", {2'b00, rd_addrs[n0]}, 8'd0);

        // Async reset while in LO.
        get_byte(b);
        chk8("arst_hi1", b, 8'h14);
        chk1("arst_pre_oe", dato_oe, 1'b1);
        chk8("arst_pre_lo", dato_out, 8'h05);
        #2 rst = 1'b1;
        #1;
        chk8("arst_dato", dato_out, 8'h00);
        chk1("arst_oe", dato_oe, 1'b0);
        chk1("arst_done", done, 1'b0);
        chk1("arst_ovr", ovr, 1'b0);
        chk1("arst_mem_rd", mem_rd, 1'b0);
        chk8("arst_addr", {2'b00, mem_addr}, 8'd0);
        rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n0 = n_rd;
        repeat (8) @(negedge clk);
        chkn("arst_no_reads", n_rd, n0);
        chk1("arst_idle_oe", dato_oe, 1'b0);
        rd = 1'b1;
        get_byte(b);
        chk8("arst_restart_hi0", b, 8'h14);
        get_byte(b);
        chk8("arst_restart_lo0", b, 8'h04);
        chk8("arst_restart_addr0", {2'b00, rd_addrs[n0]}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
